// File: rtl/ip_led_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding, bus width
// and default table constants.
package ip_led_sequencer_pkg;

   localparam int LS_ADDR_W    = 14;
   localparam int LS_DATA_W    = 8;
   localparam int LS_HOLD_W    = 24;
   localparam int LS_TIMEOUT_W = 8;

   localparam logic [LS_ADDR_W-1:0] LS_TABLE_BASE_DEF = 14'd31;
   localparam logic [LS_DATA_W-1:0] LS_TERMINATOR_DEF = 8'hE9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT_DATA,
      ST_HOLD,
      ST_ERROR
   } state_t;

   // IDLE and ERROR are the only resting states.
   function automatic logic isBusy(input state_t s);
      return (s != ST_IDLE) && (s != ST_ERROR);
   endfunction

endpackage

// File: rtl/ip_led_sequencer_timer.sv
// Hold down-counter: loads a cycle count, decrements each clock and flags
// the cycle in which it reaches one.
module ip_led_seq_timer
   import ip_led_sequencer_pkg::*;
#(
   parameter int WIDTH = LS_HOLD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_tick
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tick = (r_count == WIDTH'(1));

endmodule

// File: rtl/ip_led_sequencer.sv
// LED pattern sequencer: fetches bytes from a ROM table, shows each on led
// for HOLD_CYCLES clocks, and restarts at TABLE_BASE on the terminator byte.
// Optional read timeout is built when LED_SEQ_TIMEOUT_EN is defined.
module ip_led_sequencer
   import ip_led_sequencer_pkg::*;
#(
   parameter logic [LS_ADDR_W-1:0]    TABLE_BASE     = LS_TABLE_BASE_DEF,
   parameter logic [LS_DATA_W-1:0]    TERMINATOR     = LS_TERMINATOR_DEF,
   parameter logic [LS_HOLD_W-1:0]    HOLD_CYCLES    = 24'd65535,
   parameter logic [LS_TIMEOUT_W-1:0] TIMEOUT_CYCLES = 8'd16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic                 n_cs,
   output logic                 n_rd,
   output logic [LS_ADDR_W-1:0] address,
   input  logic [LS_DATA_W-1:0] rdata,
   input  logic                 rdata_en,
   output logic [LS_DATA_W-1:0] led,
   output logic                 busy,
   output logic                 error
);

   state_t                r_state;
   state_t                w_nextState;
   logic [LS_ADDR_W-1:0]  r_ptr;
   logic [LS_DATA_W-1:0]  r_led;
   logic                  r_wrapped;
   logic                  r_stop;

   logic w_consume;
   logic w_isTerm;
   logic w_emptyTable;
   logic w_stop;
   logic w_holdDone;
   logic w_timeout;

   assign w_consume    = (r_state == ST_WAIT_DATA) && rdata_en;
   assign w_isTerm     = (rdata == TERMINATOR);
   // A terminator straight after a wrap means the table holds no patterns.
   assign w_emptyTable = w_consume && w_isTerm && r_wrapped && (r_ptr == TABLE_BASE);
   assign w_stop       = r_stop || !enable;

   ip_led_seq_timer #(
      .WIDTH(LS_HOLD_W)
   ) u_holdTimer (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_consume && !w_isTerm),
      .i_value(HOLD_CYCLES),
      .o_tick (w_holdDone)
   );

`ifdef LED_SEQ_TIMEOUT_EN
   logic [LS_TIMEOUT_W-1:0] r_waitCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt <= '0;
      end else if (r_state == ST_REQ) begin
         r_waitCnt <= 8'd1;
      end else if (r_state == ST_WAIT_DATA) begin
         r_waitCnt <= r_waitCnt + 8'd1;
      end else begin
         r_waitCnt <= '0;
      end
   end

   assign w_timeout = (r_state == ST_WAIT_DATA) && (r_waitCnt >= (TIMEOUT_CYCLES - 8'd1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: begin
            if (enable) begin
               w_nextState = ST_REQ;
            end
         end
         ST_REQ: begin
            w_nextState = ST_WAIT_DATA;
         end
         ST_WAIT_DATA: begin
            if (w_consume) begin
               if (w_emptyTable) begin
                  w_nextState = ST_ERROR;
               end else if (w_stop) begin
                  w_nextState = ST_IDLE;
               end else if (w_isTerm) begin
                  w_nextState = ST_REQ;
               end else begin
                  w_nextState = ST_HOLD;
               end
            end else if (w_timeout) begin
               w_nextState = ST_ERROR;
            end
         end
         ST_HOLD: begin
            if (w_holdDone) begin
               w_nextState = enable ? ST_REQ : ST_IDLE;
            end
         end
         ST_ERROR: begin
            w_nextState = ST_ERROR;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      n_cs    = 1'b1;
      n_rd    = 1'b1;
      address = '0;
      if (r_state == ST_REQ) begin
         n_cs    = 1'b0;
         n_rd    = 1'b0;
         address = r_ptr;
      end
      busy  = isBusy(r_state);
      error = (r_state == ST_ERROR);
      led   = r_led;
   end

   // A read in flight always completes; a drop of enable is remembered so the
   // consumed byte sends the block to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr     <= TABLE_BASE;
         r_led     <= '0;
         r_wrapped <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         if (((r_state == ST_REQ) || (r_state == ST_WAIT_DATA)) && !enable) begin
            r_stop <= 1'b1;
         end else if ((r_state == ST_IDLE) || (r_state == ST_HOLD)) begin
            r_stop <= 1'b0;
         end
         if (w_consume) begin
            if (w_isTerm) begin
               r_ptr     <= TABLE_BASE;
               r_wrapped <= 1'b1;
            end else begin
               r_led     <= rdata;
               r_ptr     <= r_ptr + 1'b1;
               r_wrapped <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ip_led_sequencer.sv
// Self-checking bench for ip_led_sequencer: table-driven walk through the ROM
// table plus hand-written sequences for abort, reset, empty table and wrap.
module tb_ip_led_sequencer;

   typedef struct {
      logic [13:0] addr;
      logic [7:0]  led;
      int          gap;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        en2;

   logic        n_cs, n_rd, busy, error;
   logic [13:0] address;
   logic [7:0]  rdata = 8'h00;
   logic        rdata_en = 1'b0;
   logic [7:0]  led;

   logic        n_cs2, n_rd2, busy2, error2;
   logic [13:0] address2;
   logic [7:0]  rdata2 = 8'h00;
   logic        rdata_en2 = 1'b0;
   logic [7:0]  led2;

   logic [7:0]  rom [0:54];
   logic [7:0]  pat [23];
   vec_t        vecs [25];

   int          latency = 1;
   int          pend = 0;
   logic [13:0] pendAddr = '0;

   int          cyc = 0;
   logic [7:0]  ledHist [$];
   int          reqCyc [$];
   logic [13:0] reqAddr [$];

   int          nVec = 0;
   int          nMis = 0;

   always #5 clk = ~clk;

   ip_led_sequencer #(
      .TABLE_BASE    (14'd31),
      .TERMINATOR    (8'hE9),
      .HOLD_CYCLES   (24'd4),
      .TIMEOUT_CYCLES(8'd16)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .n_cs    (n_cs),
      .n_rd    (n_rd),
      .address (address),
      .rdata   (rdata),
      .rdata_en(rdata_en),
      .led     (led),
      .busy    (busy),
      .error   (error)
   );

   ip_led_sequencer #(
      .TABLE_BASE    (14'd16383),
      .TERMINATOR    (8'hE9),
      .HOLD_CYCLES   (24'd4),
      .TIMEOUT_CYCLES(8'd16)
   ) u_dut2 (
      .clk     (clk),
      .reset   (reset),
      .enable  (en2),
      .n_cs    (n_cs2),
      .n_rd    (n_rd2),
      .address (address2),
      .rdata   (rdata2),
      .rdata_en(rdata_en2),
      .led     (led2),
      .busy    (busy2),
      .error   (error2)
   );

   function automatic logic [7:0] romRead(input logic [13:0] a);
      if (a <= 14'd54) begin
         return rom[a];
      end
      return 8'h00;
   endfunction

   // ROM responder with programmable latency; latency 0 never answers.
   always @(posedge clk) begin
      rdata_en <= 1'b0;
      if (pend != 0) begin
         pend <= pend - 1;
         if (pend == 1) begin
            rdata_en <= 1'b1;
            rdata    <= romRead(pendAddr);
         end
      end
      if (!n_cs && !n_rd) begin
         if (latency == 1) begin
            rdata_en <= 1'b1;
            rdata    <= romRead(address);
         end else if (latency > 1) begin
            pend     <= latency - 1;
            pendAddr <= address;
         end
      end
   end

   // Responder for the instance whose table sits at the top of the space.
   always @(posedge clk) begin
      rdata_en2 <= 1'b0;
      if (!n_cs2 && !n_rd2) begin
         rdata_en2 <= 1'b1;
         rdata2    <= (address2 == 14'd16383) ? 8'h5A : ((address2 == 14'd0) ? 8'h3C : 8'hE9);
      end
   end

   // Per-negedge history of led and of every read request.
   always @(negedge clk) begin
      ledHist.push_back(led);
      if (!n_cs) begin
         reqCyc.push_back(cyc);
         reqAddr.push_back(address);
      end
      cyc = cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec = nVec + 1;
      if (act !== exp) begin
         nMis = nMis + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nVec = nVec + 1;
      nMis = nMis + 1;
      $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b0;
      en2    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic waitReq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!n_cs) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Waits for read number k of the main run and checks address, spacing and led.
   task automatic applyStimulus(input int base, input int k, output bit ok);
      int guard;
      int c;
      guard = 0;
      ok    = 1'b1;
      while ((reqCyc.size() <= base + k) && (guard < 100)) begin
         @(posedge clk);
         guard++;
      end
      if (reqCyc.size() <= base + k) begin
         failNow($sformatf("v%0d read", k));
         ok = 1'b0;
      end else begin
         c = reqCyc[base + k];
         checkOutput($sformatf("v%0d addr", k), 32'(reqAddr[base + k]), 32'(vecs[k].addr));
         if (vecs[k].gap != 0) begin
            checkOutput($sformatf("v%0d gap", k), 32'(c - reqCyc[base + k - 1]), 32'(vecs[k].gap));
         end
         guard = 0;
         while ((ledHist.size() <= c + 2) && (guard < 10)) begin
            @(posedge clk);
            guard++;
         end
         checkOutput($sformatf("v%0d led", k), 32'(ledHist[c + 2]), 32'(vecs[k].led));
      end
   endtask

   initial begin
      bit ok;
      int base;
      int cnt;

      pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
              8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
      for (int i = 0; i < 31; i++) begin
         rom[i] = 8'hFF;
      end
      for (int i = 0; i < 23; i++) begin
         rom[31 + i] = pat[i];
      end
      rom[54] = 8'hE9;

      for (int k = 0; k < 23; k++) begin
         vecs[k].addr = 14'(31 + k);
         vecs[k].led  = pat[k];
         vecs[k].gap  = (k == 0) ? 0 : 6;
      end
      vecs[23].addr = 14'd54;
      vecs[23].led  = 8'h81;
      vecs[23].gap  = 6;
      vecs[24].addr = 14'd31;
      vecs[24].led  = 8'h01;
      vecs[24].gap  = 2;

      reset  = 1'b1;
      enable = 1'b0;
      en2    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst n_cs", 32'(n_cs), 32'd1);
      checkOutput("rst n_rd", 32'(n_rd), 32'd1);
      checkOutput("rst address", 32'(address), 32'd0);
      checkOutput("rst led", 32'(led), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst error", 32'(error), 32'd0);
      checkOutput("rst led2", 32'(led2), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle busy", 32'(busy), 32'd0);

      $display("[TB] main table walk");
      base   = reqCyc.size();
      enable = 1'b1;
      for (int k = 0; k < 25; k++) begin
         applyStimulus(base, k, ok);
         if (!ok) begin
            break;
         end
      end
      enable = 1'b0;

      applyReset();
      @(negedge clk);
      checkOutput("reset clears led", 32'(led), 32'd0);

      $display("[TB] enable dropped during a read");
      enable = 1'b1;
      waitReq(ok);
      checkOutput("abort req seen", 32'(ok), 32'd1);
      checkOutput("abort addr", 32'(address), 32'd31);
      checkOutput("abort n_rd", 32'(n_rd), 32'd0);
      @(negedge clk);
      enable = 1'b0;
      checkOutput("abort wait busy", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("abort led", 32'(led), 32'h01);
      checkOutput("abort busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("abort idle n_cs", 32'(n_cs), 32'd1);
      enable = 1'b1;
      waitReq(ok);
      checkOutput("resume req seen", 32'(ok), 32'd1);
      checkOutput("resume addr", 32'(address), 32'd32);
      repeat (2) @(negedge clk);
      checkOutput("resume led", 32'(led), 32'h02);
      enable = 1'b0;

      $display("[TB] reset in the cycle after a read request");
      applyReset();
      latency = 3;
      enable  = 1'b1;
      waitReq(ok);
      checkOutput("midrd req addr", 32'(address), 32'd31);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midrd n_cs", 32'(n_cs), 32'd1);
      checkOutput("midrd n_rd", 32'(n_rd), 32'd1);
      checkOutput("midrd address", 32'(address), 32'd0);
      checkOutput("midrd led", 32'(led), 32'd0);
      checkOutput("midrd busy", 32'(busy), 32'd0);
      checkOutput("midrd error", 32'(error), 32'd0);
      reset  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("late rdata_en led", 32'(led), 32'd0);
      checkOutput("late rdata_en busy", 32'(busy), 32'd0);
      latency = 1;

      $display("[TB] empty table");
      rom[31] = 8'hE9;
      applyReset();
      enable = 1'b1;
      waitReq(ok);
      checkOutput("empty 1st addr", 32'(address), 32'd31);
      repeat (2) @(negedge clk);
      checkOutput("empty 2nd n_cs", 32'(n_cs), 32'd0);
      checkOutput("empty 2nd addr", 32'(address), 32'd31);
      repeat (2) @(negedge clk);
      checkOutput("empty error", 32'(error), 32'd1);
      checkOutput("empty busy", 32'(busy), 32'd0);
      checkOutput("empty led", 32'(led), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput("empty stays error", 32'(error), 32'd1);
      checkOutput("empty no read", 32'(n_cs), 32'd1);
      enable  = 1'b0;
      rom[31] = 8'h01;

      $display("[TB] table at top of address space");
      applyReset();
      en2 = 1'b1;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!n_cs2) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("top req seen", 32'(ok), 32'd1);
      checkOutput("top addr", 32'(address2), 32'd16383);
      repeat (2) @(negedge clk);
      checkOutput("top led", 32'(led2), 32'h5A);
      cnt = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt++;
         if (!n_cs2) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("wrap req seen", 32'(ok), 32'd1);
      checkOutput("wrap gap", 32'(cnt), 32'd4);
      checkOutput("wrap addr", 32'(address2), 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("wrap led", 32'(led2), 32'h3C);
      en2 = 1'b0;

      $display("[TB] responder that never answers");
      applyReset();
      latency = 0;
      enable  = 1'b1;
      waitReq(ok);
      checkOutput("silent req addr", 32'(address), 32'd31);
`ifdef LED_SEQ_TIMEOUT_EN
      cnt = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         cnt++;
         if (error) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("timeout seen", 32'(ok), 32'd1);
      checkOutput("timeout delay", 32'(cnt), 32'd16);
      repeat (3) @(negedge clk);
      checkOutput("timeout n_cs", 32'(n_cs), 32'd1);
`else
      repeat (30) @(negedge clk);
      checkOutput("no timeout error", 32'(error), 32'd0);
      checkOutput("no timeout busy", 32'(busy), 32'd1);
      checkOutput("no timeout n_cs", 32'(n_cs), 32'd1);
`endif
      enable  = 1'b0;
      latency = 1;
      applyReset();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no end of test, expected one within 100000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
